// File: rtl/acorn128_crypt_stream.sv
// ACORN-128 message encrypt/decrypt engine with built-in 256-step padding.
// W state-update steps are chained per clock; the post-padding state feeds the tag block.
module acorn128_crypt_stream #(
    parameter int unsigned W     = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [LEN_W-1:0] msg_len_i,
    input  logic [292:0]     state_in_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic [W-1:0]     din_i,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic [W-1:0]     dout_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [292:0]     state_out_o
);

    localparam int unsigned SW      = 293;
    localparam int unsigned SHIFT   = $clog2(W);
    localparam int unsigned PAD_CYC = 256 / W;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned P_W     = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MSG,
        ST_PAD,
        ST_DONE
    } state_e;

    state_e           state_q;
    logic [SW-1:0]    s_q;
    logic [SW-1:0]    s_d;
    logic [W-1:0]     o_d;
    logic             dec_q;
    logic [LEN_W-1:0] words_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic [PC_W-1:0]  pad_cnt_q;
    logic [W-1:0]     dout_q;
    logic             dout_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [SW-1:0]    state_out_q;
    logic             din_fire;
    logic [LEN_W-1:0] start_words;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    assign din_ready_o  = (state_q == ST_MSG) && (!dout_valid_q || dout_ready_i);
    assign din_fire     = din_ready_o && din_valid_i;
    assign start_words  = msg_len_i >> SHIFT;
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign state_out_o  = state_out_q;

    // W chained state-update steps; cb is 0 in every phase this block covers.
    always_comb begin : step_chain
        logic [SW-1:0] s_v;
        logic [W-1:0]  o_v;
        logic [P_W-1:0] p_v;
        logic ks_v;
        logic f_v;
        logic a_v;
        logic m_v;
        s_v  = s_q;
        o_v  = '0;
        p_v  = '0;
        ks_v = 1'b0;
        f_v  = 1'b0;
        a_v  = 1'b0;
        m_v  = 1'b0;
        for (int j = 0; j < int'(W); j++) begin
            p_v = P_W'(pad_cnt_q) * P_W'(W) + P_W'(j);
            s_v[289] = s_v[289] ^ s_v[235] ^ s_v[230];
            s_v[230] = s_v[230] ^ s_v[196] ^ s_v[193];
            s_v[193] = s_v[193] ^ s_v[160] ^ s_v[154];
            s_v[154] = s_v[154] ^ s_v[111] ^ s_v[107];
            s_v[107] = s_v[107] ^ s_v[66]  ^ s_v[61];
            s_v[61]  = s_v[61]  ^ s_v[23]  ^ s_v[0];
            ks_v = s_v[12] ^ s_v[154] ^ maj(s_v[235], s_v[61], s_v[193])
                 ^ ch(s_v[230], s_v[111], s_v[66]);
            if (state_q == ST_MSG) begin
                a_v    = 1'b1;
                o_v[j] = din_i[j] ^ ks_v;
                m_v    = dec_q ? o_v[j] : din_i[j];
            end else begin
                a_v = (p_v < P_W'(128));
                m_v = (p_v == P_W'(0));
            end
            f_v = s_v[0] ^ ~s_v[107] ^ maj(s_v[244], s_v[23], s_v[160]) ^ (a_v & s_v[196]);
            s_v = {f_v ^ m_v, s_v[SW-1:1]};
        end
        s_d = s_v;
        o_d = o_v;
    end

    // Control FSM, state register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            dec_q        <= 1'b0;
            words_q      <= '0;
            word_cnt_q   <= '0;
            pad_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            state_out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (dout_valid_q && dout_ready_i && !din_fire) begin
                dout_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        s_q        <= state_in_i;
                        dec_q      <= decrypt_i;
                        words_q    <= start_words;
                        word_cnt_q <= '0;
                        pad_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (start_words != '0) ? ST_MSG : ST_PAD;
                    end
                end
                ST_MSG: begin
                    if (din_fire) begin
                        s_q          <= s_d;
                        dout_q       <= o_d;
                        dout_valid_q <= 1'b1;
                        word_cnt_q   <= word_cnt_q + LEN_W'(1);
                        if (word_cnt_q == words_q - LEN_W'(1)) begin
                            state_q <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    s_q       <= s_d;
                    pad_cnt_q <= pad_cnt_q + PC_W'(1);
                    if (pad_cnt_q == PC_W'(PAD_CYC - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_out_q <= s_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn128_crypt_stream.sv
// Bench for acorn128_crypt_stream: W=8, W=1 and W=32 instances checked against
// a bit-serial reference model of the cipher.
module tb_acorn128_crypt_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         decrypt;
    logic [15:0]  msg_len;
    logic [292:0] state_in;

    logic start8, din_valid8, din_ready8, dout_valid8, dout_ready8, busy8, done8;
    logic [7:0] din8, dout8;
    logic [292:0] so8;
    logic start1, din_valid1, din_ready1, dout_valid1, dout_ready1, busy1, done1;
    logic [0:0] din1, dout1;
    logic [292:0] so1;
    logic start32, din_valid32, din_ready32, dout_valid32, dout_ready32, busy32, done32;
    logic [31:0] din32, dout32;
    logic [292:0] so32;

    acorn128_crypt_stream #(.W(8), .LEN_W(16)) u8 (
        .clk(clk), .rst(rst), .start_i(start8), .decrypt_i(decrypt), .msg_len_i(msg_len),
        .state_in_i(state_in), .din_valid_i(din_valid8), .din_ready_o(din_ready8), .din_i(din8),
        .dout_valid_o(dout_valid8), .dout_ready_i(dout_ready8), .dout_o(dout8),
        .busy_o(busy8), .done_o(done8), .state_out_o(so8));

    acorn128_crypt_stream #(.W(1), .LEN_W(16)) u1 (
        .clk(clk), .rst(rst), .start_i(start1), .decrypt_i(decrypt), .msg_len_i(msg_len),
        .state_in_i(state_in), .din_valid_i(din_valid1), .din_ready_o(din_ready1), .din_i(din1),
        .dout_valid_o(dout_valid1), .dout_ready_i(dout_ready1), .dout_o(dout1),
        .busy_o(busy1), .done_o(done1), .state_out_o(so1));

    acorn128_crypt_stream #(.W(32), .LEN_W(16)) u32 (
        .clk(clk), .rst(rst), .start_i(start32), .decrypt_i(decrypt), .msg_len_i(msg_len),
        .state_in_i(state_in), .din_valid_i(din_valid32), .din_ready_o(din_ready32), .din_i(din32),
        .dout_valid_o(dout_valid32), .dout_ready_i(dout_ready32), .dout_o(dout32),
        .busy_o(busy32), .done_o(done32), .state_out_o(so32));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int idx8, idx1, idx32, oc8, oc1, oc32;
    int lf8, lf1, lf32, dc8, dc1, dc32;
    bit dn8, dn1, dn32, saw_rdy8;
    logic [255:0] msg_v, ct8, ct1, ct32;

    task automatic chk(input string tag, input logic [292:0] obs, input logic [292:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one cipher step on a whole 293-bit state, one bit at a time.
    function automatic bit maj3(input bit x, input bit y, input bit z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    task automatic m_step(inout logic [292:0] s, input bit a, input bit dec, input bit is_msg,
                          input bit inb, output bit ob);
        bit ks, f, m;
        s[289] ^= s[235] ^ s[230];
        s[230] ^= s[196] ^ s[193];
        s[193] ^= s[160] ^ s[154];
        s[154] ^= s[111] ^ s[107];
        s[107] ^= s[66] ^ s[61];
        s[61]  ^= s[23] ^ s[0];
        ks = s[12] ^ s[154] ^ maj3(s[235], s[61], s[193]) ^ (s[230] ? s[111] : s[66]);
        f  = s[0] ^ ~s[107] ^ maj3(s[244], s[23], s[160]) ^ (a & s[196]);
        ob = inb ^ ks;
        m  = is_msg ? (dec ? ob : inb) : inb;
        s  = {f ^ m, s[292:1]};
    endtask

    task automatic model_run(input logic [292:0] s0, input int len, input bit dec,
                             input logic [255:0] inv, output logic [255:0] outv,
                             output logic [292:0] sf);
        logic [292:0] s;
        bit ob;
        s = s0;
        outv = '0;
        for (int i = 0; i < len; i++) begin
            m_step(s, 1'b1, dec, 1'b1, inv[i], ob);
            outv[i] = ob;
        end
        for (int p = 0; p < 256; p++) begin
            m_step(s, (p < 128), dec, 1'b0, (p == 0), ob);
        end
        sf = s;
    endtask

    function automatic logic [292:0] rand_state();
        logic [319:0] t;
        for (int k = 0; k < 10; k++) t[k*32 +: 32] = $urandom;
        return t[292:0];
    endfunction

    function automatic logic [255:0] rand_msg();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic set_din();
        din8 = '0; din1 = '0; din32 = '0;
        if (idx8 * 8 < 256) din8 = msg_v[idx8*8 +: 8];
        if (idx1 < 256) din1 = msg_v[idx1 +: 1];
        if (idx32 * 32 < 256) din32 = msg_v[idx32*32 +: 32];
    endtask

    // One clock: sample pre-edge handshakes, step the edge, then update bookkeeping.
    task automatic tick();
        bit f8, f1, f32;
        #1;
        f8  = din_valid8 & din_ready8;
        f1  = din_valid1 & din_ready1;
        f32 = din_valid32 & din_ready32;
        if (din_ready8) saw_rdy8 = 1'b1;
        if (dout_valid8 && dout_ready8) begin
            if (oc8 < 256) ct8[oc8 +: 8] = dout8;
            oc8 += 8;
        end
        if (dout_valid1 && dout_ready1) begin
            if (oc1 < 256) ct1[oc1 +: 1] = dout1;
            oc1 += 1;
        end
        if (dout_valid32 && dout_ready32) begin
            if (oc32 < 256) ct32[oc32 +: 32] = dout32;
            oc32 += 32;
        end
        @(posedge clk);
        cyc++;
        if (f8) lf8 = cyc;
        if (f1) lf1 = cyc;
        if (f32) lf32 = cyc;
        @(negedge clk);
        start8 = 1'b0; start1 = 1'b0; start32 = 1'b0;
        if (f8) idx8++;
        if (f1) idx1++;
        if (f32) idx32++;
        if (done8 && !dn8) begin dn8 = 1'b1; dc8 = cyc; end
        if (done1 && !dn1) begin dn1 = 1'b1; dc1 = cyc; end
        if (done32 && !dn32) begin dn32 = 1'b1; dc32 = cyc; end
    endtask

    task automatic run_op(input bit e8, input bit e1, input bit e32, input logic [292:0] s0,
                          input int len, input bit dec, input bit stall, input int kick,
                          input logic [292:0] s_alt, output int t0);
        bit all_done;
        state_in = s0; msg_len = 16'(len); decrypt = dec;
        idx8 = 0; idx1 = 0; idx32 = 0; oc8 = 0; oc1 = 0; oc32 = 0;
        dn8 = 0; dn1 = 0; dn32 = 0; dc8 = -1; dc1 = -1; dc32 = -1;
        lf8 = -1; lf1 = -1; lf32 = -1; saw_rdy8 = 0;
        ct8 = '0; ct1 = '0; ct32 = '0;
        start8 = e8; start1 = e1; start32 = e32;
        t0 = cyc + 1;
        all_done = 1'b0;
        for (int k = 0; k < 3000 && !all_done; k++) begin
            if (k == kick) begin
                start8 = 1'b1; state_in = s_alt; msg_len = '0;
            end
            din_valid8  = e8 && (idx8 * 8 < len);
            din_valid1  = e1 && (idx1 < len);
            din_valid32 = e32 && (idx32 * 32 < len);
            dout_ready8 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready1 = 1'b1; dout_ready32 = 1'b1;
            set_din();
            tick();
            all_done = (!e8 || dn8) && (!e1 || dn1) && (!e32 || dn32);
        end
        chk("op_completes", 293'(all_done), 293'(1'b1));
        din_valid8 = 0; din_valid1 = 0; din_valid32 = 0;
        dout_ready8 = 1; dout_ready1 = 1; dout_ready32 = 1;
        repeat (3) begin set_din(); tick(); end
    endtask

    logic [292:0] s, s2, ms, so_keep;
    logic [255:0] mo, pt_keep, ct_keep;
    int t0;

    initial begin
        rst = 1'b1;
        start8 = 0; start1 = 0; start32 = 0;
        din_valid8 = 0; din_valid1 = 0; din_valid32 = 0;
        dout_ready8 = 1; dout_ready1 = 1; dout_ready32 = 1;
        din8 = '0; din1 = '0; din32 = '0;
        decrypt = 0; msg_len = '0; state_in = '0; msg_v = '0;
        idx8 = 0; idx1 = 0; idx32 = 0; oc8 = 0; oc1 = 0; oc32 = 0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", 293'(busy8), 293'(1'b0));
        chk("rst_done", 293'(done8), 293'(1'b0));
        chk("rst_dout_valid", 293'(dout_valid8), 293'(1'b0));
        chk("rst_din_ready", 293'(din_ready8), 293'(1'b0));
        chk("rst_dout", 293'(dout8), 293'(0));
        chk("rst_state_out", so8, 293'(0));
        @(negedge clk);
        rst = 1'b0;

        // W=1, zero state, 8 zero bits
        msg_v = '0;
        run_op(0, 1, 0, '0, 8, 0, 0, -1, '0, t0);
        model_run('0, 8, 0, msg_v, mo, ms);
        chk("w1_first_bit", 293'(ct1[0]), 293'(1'b0));
        chk("w1_ct", 293'(ct1[7:0]), 293'(mo[7:0]));
        chk("w1_count", 293'(oc1), 293'(8));
        chk("w1_state", so1, ms);
        chk("w1_done_lat", 293'(dc1), 293'(lf1 + 257));

        // W=8, padding only
        s = rand_state();
        msg_v = rand_msg();
        run_op(1, 0, 0, s, 0, 0, 0, -1, '0, t0);
        model_run(s, 0, 0, msg_v, mo, ms);
        chk("pad_no_ready", 293'(saw_rdy8), 293'(1'b0));
        chk("pad_done_lat", 293'(dc8), 293'(t0 + 33));
        chk("pad_state", so8, ms);

        // W=8 encrypt then decrypt 128 bits
        s = rand_state();
        msg_v = rand_msg();
        pt_keep = msg_v;
        run_op(1, 0, 0, s, 128, 0, 0, -1, '0, t0);
        model_run(s, 128, 0, msg_v, mo, ms);
        chk("enc_ct", 293'(ct8[127:0]), 293'(mo[127:0]));
        chk("enc_state", so8, ms);
        ct_keep = ct8;
        so_keep = so8;
        msg_v = ct_keep;
        run_op(1, 0, 0, s, 128, 1, 0, -1, '0, t0);
        chk("dec_pt", 293'(ct8[127:0]), 293'(pt_keep[127:0]));
        chk("dec_state", so8, ms);
        chk("dec_done_lat", 293'(dc8), 293'(lf8 + 33));

        // W=1 and W=32 on the same 256-bit message
        s = rand_state();
        msg_v = rand_msg();
        run_op(0, 1, 1, s, 256, 0, 0, -1, '0, t0);
        model_run(s, 256, 0, msg_v, mo, ms);
        chk("w1_w32_ct", 293'(ct1), 293'(ct32));
        chk("w1_w32_state", so1, so32);
        chk("w32_ct_model", 293'(ct32), 293'(mo));
        chk("w32_state_model", so32, ms);
        chk("w32_count", 293'(oc32), 293'(256));
        chk("w32_done_lat", 293'(dc32), 293'(lf32 + 9));

        // W=8 with random output backpressure vs unstalled run
        s = rand_state();
        msg_v = rand_msg();
        run_op(1, 0, 0, s, 64, 0, 0, -1, '0, t0);
        ct_keep = ct8;
        so_keep = so8;
        run_op(1, 0, 0, s, 64, 0, 1, -1, '0, t0);
        model_run(s, 64, 0, msg_v, mo, ms);
        chk("bp_count", 293'(oc8), 293'(64));
        chk("bp_ct_vs_nostall", 293'(ct8[63:0]), 293'(ct_keep[63:0]));
        chk("bp_state_vs_nostall", so8, so_keep);
        chk("bp_ct_model", 293'(ct8[63:0]), 293'(mo[63:0]));
        chk("bp_state_model", so8, ms);

        // reset mid-message, then an ignored start while busy
        s = rand_state();
        msg_v = rand_msg();
        state_in = s; msg_len = 16'd128; decrypt = 0;
        idx8 = 0; oc8 = 0; start8 = 1;
        repeat (6) begin
            din_valid8 = 1; dout_ready8 = 1;
            set_din();
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 293'(busy8), 293'(1'b0));
        chk("mid_rst_done", 293'(done8), 293'(1'b0));
        chk("mid_rst_dout_valid", 293'(dout_valid8), 293'(1'b0));
        chk("mid_rst_din_ready", 293'(din_ready8), 293'(1'b0));
        chk("mid_rst_dout", 293'(dout8), 293'(0));
        chk("mid_rst_state_out", so8, 293'(0));
        @(negedge clk);
        rst = 1'b0;
        din_valid8 = 0;
        s = rand_state();
        s2 = rand_state();
        msg_v = rand_msg();
        run_op(1, 0, 0, s, 8, 0, 0, 2, s2, t0);
        model_run(s, 8, 0, msg_v, mo, ms);
        chk("after_rst_ct", 293'(ct8[7:0]), 293'(mo[7:0]));
        chk("after_rst_state", so8, ms);
        chk("after_rst_done_lat", 293'(dc8), 293'(t0 + 34));
        chk("after_rst_count", 293'(oc8), 293'(8));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acorn128_crypt_stream.md
# acorn128_crypt_stream

Parametrised ACORN-128 encrypt/decrypt engine that processes W message bits per clock, with valid/ready streaming on input and output, runtime message length, and built-in 256-step padding. It sits after the associated-data phase: it takes the 293-bit state from that phase and returns the post-padding state for the finalisation/tag block.

## Interface
- W, default 8: bits processed per cycle; legal values 1, 2, 4, 8, 16, 32.
- LEN_W, default 16: width of the message length field, in bits.
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- start in 1: one-cycle command; accepted only while busy=0.
- decrypt in 1: sampled with start; 0 selects encrypt, 1 selects decrypt.
- msg_len in LEN_W: message length in bits, sampled with start; must be a multiple of W.
- state_in in 293: initial state, sampled with start.
- din_valid, din_ready in 1 / out 1: input word handshake.
- din in W: plaintext (encrypt) or ciphertext (decrypt); bit 0 is the earliest bit.
- dout_valid, dout_ready out 1 / in 1: output word handshake.
- dout out W: ciphertext (encrypt) or plaintext (decrypt).
- busy out 1: high from the cycle after start until done.
- done out 1: one-cycle pulse when padding completes.
- state_out out 293: final state; valid from done, held until the next start.

## Operation
- One step (S = 293-bit state, a = ca, b = cb, m = message bit):
  - S289^=S235^S230
  - S230^=S196^S193
  - S193^=S160^S154
  - S154^=S111^S107
  - S107^=S66^S61
  - S61^=S23^S0
  - ks = S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66)
  - f = S0^~S107^maj(S244,S23,S160)^(a&S196)^(b&ks)
  - S shifts down by one, then S292 = f^m.
  - maj and ch are evaluated on the updated values.
- Each cycle chains W steps combinationally. Step j uses the state produced by step j-1.
- FSM states: IDLE, MSG, PAD, DONE.
- IDLE:
  - start latches state_in, decrypt, msg_len, clears counters, and asserts busy.
  - Next state is MSG if msg_len≠0, otherwise PAD.
- MSG (din_ready = !dout_valid | dout_ready):
  - On a din handshake, step j uses a=1, b=0, o_j = din[j]^ks_j.
  - Encrypt uses m = din[j]; decrypt uses m = o_j.
  - dout <= o and dout_valid <= 1.
  - After msg_len/W words the FSM moves to PAD.
- PAD: runs 256/W cycles with no handshake.
  - Global pad index p = 0..255.
  - m = 1 at p=0, otherwise 0.
  - a = 1 for p<128, 0 for p≥128; b = 0.
- DONE: state_out <= S, done=1 for one cycle, busy drops, next state IDLE.
- dout_valid clears on a dout handshake that has no new din word in the same cycle. It is independent of the FSM, so the final output word may still be pending during PAD/DONE.
- start while busy=1 is ignored. A msg_len that is not a multiple of W is truncated to floor(msg_len/W) words.
- Reset clears:
  - FSM to IDLE
  - busy, done, dout_valid, din_ready
  - dout = 0, state_out = 0
  - all counters
- A reset asserted mid-operation abandons the message; no done is produced.

## Timing
- Input to output latency is 1 cycle: din accepted at edge k gives dout_valid at k+1.
- Throughput is W bits/cycle with dout_ready held high.
- While dout_valid=1 and dout_ready=0, din_ready=0 and the state does not advance.
- A simultaneous dout handshake and din handshake in the same cycle are both accepted, with no bubble.
- start at edge t0 gives busy=1 at t0+1.
- For msg_len=0, done=1 at t0+256/W+1.
- Padding adds exactly 256/W cycles after the last MSG word, then done follows.
- din_ready is 0 in IDLE, PAD and DONE.

## Test plan
- W=1, state_in=0, msg_len=8, din bits all 0 → first dout bit = 0.
  - All 8 output bits and state_out must match the C model.
  - done arrives exactly 256 cycles after the last word plus 1.
- W=8, msg_len=0, random state_in → no din_ready.
  - done exactly 33 cycles after start; state_out matches the C model padding-only result.
- W=8, msg_len=128, random state and data → encrypt, then decrypt the ciphertext from the same state_in.
  - The recovered plaintext must equal the original, and state_out must be identical in both runs.
- W=1 vs W=32 instances, same 256-bit message and state → identical ciphertext bitstream and identical state_out.
- Random dout_ready backpressure (50%) with W=8, msg_len=64 → no lost or duplicated words; state_out matches the no-stall run.
- Reset pulsed mid-MSG, then start asserted during busy → rst clears all outputs immediately, and the ignored start changes nothing.
  - A fresh start with msg_len=8 then completes normally and matches the C model.
